pipe_stage_buf: RTL and testbench

//  Elastic inter-stage pipeline buffer for the core pipeline (IF/ID, ID/EX, ...).

---
 rtl/pipe_stage_buf_pkg.sv | 30 +++
 rtl/pipe_stage_buf.sv | 93 +++++++++
 tb/tb_pipe_stage_buf.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the inter-stage pipeline buffers: per-stage payload
// structs, common integer aliases and the pointer wrap helper.
package pipe_stage_buf_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    // Per-stage payloads; instantiate the buffer with WIDTH=$bits(<type>) and cast.
    typedef struct packed {
        u64          pc;
        logic [31:0] instr;
        logic        predTaken;
    } fetch_data_t;

    typedef struct packed {
        u64         pc;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        u64         imm;
        logic [7:0] opcode;
    } decode_data_t;

    // Advance a pointer by one, wrapping at depth. The explicit compare keeps
    // non-power-of-two depths correct.
    function automatic int unsigned ptrWrapInc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready buffer between core pipeline stages (IF/ID, ID/EX, ...).
// A DEPTH-entry circular FIFO; flush squashes every in-flight entry.
// Build macro PIPE_STAGE_BUF_PERF_EN adds the stall_cycles / flush_count counters.
//
// Handshake: a transfer happens at a rising clk edge when valid and ready are
// both high on that side (push = in_valid & in_ready, pop = out_valid & out_ready).
// in_ready and out_valid are functions of registered occupancy only, so there is
// no combinational path from out_ready to in_ready, nor from in_data to out_data.
// A producer seeing in_ready=0 must hold in_data stable; it is not sampled.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output u32               stall_cycles,
    output u32               flush_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] occ;
    logic             push;
    logic             pop;
    logic             squash;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return PTR_W'(ptrWrapInc(32'(p), DEPTH));
    endfunction

    // Handshake decode and masked head output; bubbles always read as zero.
    assign in_ready  = (occ != FULL_CNT);
    assign out_valid = (occ != '0);
    assign out_data  = out_valid ? mem[rdPtr] : '0;
    assign count     = occ;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign squash    = reset | flush;

    // Pointer and occupancy update; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (squash) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage write; contents are not cleared, a squashed push is simply dropped.
    always_ff @(posedge clk) begin
        if (push && !squash) mem[wrPtr] <= in_data;
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    // Free-running performance counters, cleared only by reset, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (in_valid && !in_ready) stall_cycles <= stall_cycles + 32'd1;
            if (flush)                 flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf with DEPTH=2, DEPTH=3 and DEPTH=1 instances.
// Perf counter checks are compiled when PIPE_STAGE_BUF_PERF_EN is defined.
module tb_pipe_stage_buf;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;

    // DEPTH=2 instance
    logic         aFlush, aInValid, aInReady, aOutValid, aOutReady;
    logic [W-1:0] aInData, aOutData;
    logic [1:0]   aCount;
    // DEPTH=3 instance
    logic         bFlush, bInValid, bInReady, bOutValid, bOutReady;
    logic [W-1:0] bInData, bOutData;
    logic [1:0]   bCount;
    // DEPTH=1 instance
    logic         cFlush, cInValid, cInReady, cOutValid, cOutReady;
    logic [W-1:0] cInData, cOutData;
    logic [0:0]   cCount;
`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0]  cStall, cFlushCnt;
`endif

    int nChecks = 0;
    int nPass   = 0;
    logic [W-1:0] expQ[$];

    // Clock and reset
    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) dutA (
        .clk(clk), .reset(reset), .flush(aFlush),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .count(aCount)
    );

    pipe_stage_buf #(.WIDTH(W), .DEPTH(3)) dutB (
        .clk(clk), .reset(reset), .flush(bFlush),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .count(bCount)
    );

    pipe_stage_buf #(.WIDTH(W), .DEPTH(1)) dutC (
        .clk(clk), .reset(reset), .flush(cFlush),
        .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData),
        .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData),
        .count(cCount)
`ifdef PIPE_STAGE_BUF_PERF_EN
        ,
        .stall_cycles(cStall), .flush_count(cFlushCnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            nPass++;
    endtask

    // Advance one clock; inputs set after this are applied at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        logic doPush;
        logic doPop;
        logic [W-1:0] head;

        reset = 1'b1;
        aFlush = 0; aInValid = 0; aOutReady = 0; aInData = '0;
        bFlush = 0; bInValid = 0; bOutReady = 0; bInData = '0;
        cFlush = 0; cInValid = 0; cOutReady = 0; cInData = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_count",    aCount, 0);
        check("rst_in_ready", aInReady, 1);
        check("rst_out_vld",  aOutValid, 0);
        check("rst_out_data", aOutData, 0);
        check("rst_b_count",  bCount, 0);
        check("rst_c_count",  cCount, 0);

        // Test 1: fill DEPTH=2 with downstream stalled
        aInValid = 1; aInData = 16'h11; aOutReady = 0;
        tick();
        check("t1_lat_vld",  aOutValid, 1);
        check("t1_lat_data", aOutData, 16'h11);
        aInData = 16'h22;
        tick();
        aInValid = 0;
        check("t1_count",    aCount, 2);
        check("t1_in_ready", aInReady, 0);
        check("t1_out_data", aOutData, 16'h11);

        // Test 3: flush while full with a same-cycle push offered
        aFlush = 1; aInValid = 1; aInData = 16'h33;
        tick();
        aFlush = 0; aInValid = 0; aInData = '0;
        check("t3_count",    aCount, 0);
        check("t3_out_vld",  aOutValid, 0);
        check("t3_out_data", aOutData, 0);
        check("t3_in_ready", aInReady, 1);
        aOutReady = 1;
        tick();
        check("t3_no_ghost", aOutValid, 0);

        // Test 2: streaming at full throughput
        aInValid = 1; aOutReady = 1;
        for (int k = 1; k <= 8; k++) begin
            aInData = W'(k);
            tick();
            check("t2_data",  aOutData, k);
            check("t2_count", aCount, 1);
        end
        aInValid = 0;
        tick();
        check("t2_drain", aCount, 0);
        aOutReady = 0;

        // Test 4: DEPTH=3 with random downstream backpressure
        expQ.delete();
        sent = 0; recv = 0; cyc = 0;
        while (recv < 10 && cyc < 200) begin
            check("t4_count",    bCount, expQ.size());
            check("t4_in_ready", bInReady, expQ.size() != 3);
            check("t4_out_vld",  bOutValid, expQ.size() != 0);
            bInValid  = (sent < 10);
            bInData   = W'(16'hA0 + sent);
            bOutReady = 1'($urandom_range(0, 1));
            doPush = bInValid & bInReady;
            doPop  = bOutValid & bOutReady;
            if (doPop) begin
                head = (expQ.size() != 0) ? expQ.pop_front() : '0;
                check("t4_order", bOutData, head);
                recv++;
            end
            if (doPush) begin
                expQ.push_back(bInData);
                sent++;
            end
            tick();
            cyc++;
        end
        bInValid = 0; bOutReady = 0;
        check("t4_all_recv", recv, 10);

        // DEPTH=1: half throughput under continuous offer
        cInValid = 1; cOutReady = 1; cInData = 16'h5A;
        tick();
        check("d1_fill_count", cCount, 1);
        check("d1_fill_rdy",   cInReady, 0);
        check("d1_fill_data",  cOutData, 16'h5A);
        tick();
        check("d1_pop_count",  cCount, 0);
        check("d1_pop_rdy",    cInReady, 1);
        cInValid = 0; cOutReady = 0;

        // Test 5: reset together with flush while holding two entries
        aInValid = 1; aOutReady = 0; aInData = 16'h55;
        tick();
        aInData = 16'h66;
        tick();
        aInValid = 0;
        check("t5_pre_count", aCount, 2);
        reset = 1; aFlush = 1;
        tick();
        reset = 0; aFlush = 0;
        check("t5_count",    aCount, 0);
        check("t5_in_ready", aInReady, 1);
        check("t5_out_data", aOutData, 0);
        check("t5_out_vld",  aOutValid, 0);

`ifdef PIPE_STAGE_BUF_PERF_EN
        // Test 6: perf counters on DEPTH=1
        check("t6_rst_stall", cStall, 0);
        check("t6_rst_flush", cFlushCnt, 0);
        cInValid = 1; cOutReady = 0; cInData = 16'h77;
        for (int k = 0; k < 5; k++) tick();
        cInValid = 0;
        check("t6_stall", cStall, 4);
        for (int k = 0; k < 2; k++) begin
            cFlush = 1;
            tick();
            cFlush = 0;
            tick();
        end
        check("t6_flush_cnt",  cFlushCnt, 2);
        check("t6_stall_keep", cStall, 4);
        check("t6_count",      cCount, 0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
